// File: rtl/order_book_pkg.sv
// order_book_pkg
// Shared types and default widths for the two-sided order book and the
// feed-handler order decoder that drives it.
//   req_type_e  : request encoding on the req_type port
//   status_e    : response encoding on the resp_status port
//   SIDE_BID/ASK: side port encoding
//   ob_state_e  : book control FSM states
package order_book_pkg;

    localparam int OB_DEPTH   = 16;
    localparam int OB_ID_W    = 32;
    localparam int OB_QTY_W   = 32;
    localparam int OB_PRICE_W = 64;

    localparam logic SIDE_BID = 1'b0;
    localparam logic SIDE_ASK = 1'b1;

    typedef enum logic [1:0] {
        REQ_ADD    = 2'b00,
        REQ_CANCEL = 2'b01,
        REQ_REDUCE = 2'b10,
        REQ_RSVD   = 2'b11
    } req_type_e;

    typedef enum logic [1:0] {
        STAT_OK        = 2'd0,
        STAT_FULL      = 2'd1,
        STAT_NOT_FOUND = 2'd2,
        STAT_BAD_REQ   = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_RESCAN = 2'd2
    } ob_state_e;

endpackage

// File: rtl/ob_free_slot_enc.sv
// ob_free_slot_enc
// Finds the lowest-index free entry of one book side.
//   valid_vec : entry valid bits (1 = occupied)
//   free_idx  : lowest index whose valid bit is 0 (0 when none is free)
//   any_free  : at least one entry is free
module ob_free_slot_enc #(
    parameter int N = 16
) (
    input  logic [N-1:0]         valid_vec,
    output logic [$clog2(N)-1:0] free_idx,
    output logic                 any_free
);

    localparam int IDX_W = $clog2(N);

    // Walking from the top down lets the lowest free index win last.
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                free_idx = IDX_W'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/param_order_book.sv
// param_order_book
// Two-sided limit order book with DEPTH resting entries per side.
//   clk, reset (sync, active-low)
//   in_valid/in_ready, req_type, side, order_id, quantity, price : request
//   resp_valid, resp_status : one-cycle response per accepted request
//   bid_*/ask_* : registered best order per side (valid, id, qty, price)
module param_order_book
    import order_book_pkg::*;
#(
    parameter int DEPTH   = OB_DEPTH,
    parameter int ID_W    = OB_ID_W,
    parameter int QTY_W   = OB_QTY_W,
    parameter int PRICE_W = OB_PRICE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         req_type,
    input  logic               side,
    input  logic [ID_W-1:0]    order_id,
    input  logic [QTY_W-1:0]   quantity,
    input  logic [PRICE_W-1:0] price,
    output logic               resp_valid,
    output logic [1:0]         resp_status,
    output logic               bid_valid,
    output logic [ID_W-1:0]    bid_id,
    output logic [QTY_W-1:0]   bid_qty,
    output logic [PRICE_W-1:0] bid_price,
    output logic               ask_valid,
    output logic [ID_W-1:0]    ask_id,
    output logic [QTY_W-1:0]   ask_qty,
    output logic [PRICE_W-1:0] ask_price
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    // Per-side storage, indexed [side][entry].
    logic [DEPTH-1:0]   ent_valid [2];
    logic [ID_W-1:0]    ent_id    [2][DEPTH];
    logic [QTY_W-1:0]   ent_qty   [2][DEPTH];
    logic [PRICE_W-1:0] ent_price [2][DEPTH];

    // Registered best order per side; best_idx_r identifies which entry it is.
    logic               best_valid_r [2];
    logic [IDX_W-1:0]   best_idx_r   [2];
    logic [ID_W-1:0]    best_id_r    [2];
    logic [QTY_W-1:0]   best_qty_r   [2];
    logic [PRICE_W-1:0] best_price_r [2];

    ob_state_e          state;
    req_type_e          type_q;
    logic               side_q;
    logic [ID_W-1:0]    id_q;
    logic [QTY_W-1:0]   qty_q;
    logic [IDX_W-1:0]   idx_q;
    status_e            resp_status_r;

    // Running best candidate while rescanning.
    logic               scan_found;
    logic [IDX_W-1:0]   scan_idx;
    logic [PRICE_W-1:0] scan_price;

    logic [IDX_W-1:0]   free_idx [2];
    logic [1:0]         any_free;

    for (genvar s = 0; s < 2; s++) begin : g_enc
        ob_free_slot_enc #(.N(DEPTH)) u_enc (
            .valid_vec (ent_valid[s]),
            .free_idx  (free_idx[s]),
            .any_free  (any_free[s])
        );
    end

    // Strict price improvement: higher for bids, lower for asks.
    function automatic logic better(input logic s,
                                    input logic [PRICE_W-1:0] a,
                                    input logic [PRICE_W-1:0] b);
        return (s == SIDE_BID) ? (a > b) : (a < b);
    endfunction

    logic               add_better;
    logic               hit;
    logic               hit_is_best;
    logic               hit_remove;
    logic [QTY_W-1:0]   hit_qty;
    logic [QTY_W-1:0]   reduced_qty;
    logic               take_cur;
    logic               final_found;
    logic [IDX_W-1:0]   final_idx;

    always_comb begin
        add_better  = !best_valid_r[side] || better(side, price, best_price_r[side]);
        hit_qty     = ent_qty[side_q][idx_q];
        hit         = ent_valid[side_q][idx_q] && (ent_id[side_q][idx_q] == id_q);
        hit_is_best = best_valid_r[side_q] && (best_idx_r[side_q] == idx_q);
        hit_remove  = (type_q == REQ_CANCEL) || (qty_q >= hit_qty);
        reduced_qty = hit_qty - qty_q;
        take_cur    = ent_valid[side_q][idx_q] &&
                      (!scan_found || better(side_q, ent_price[side_q][idx_q], scan_price));
        final_found = scan_found || take_cur;
        final_idx   = take_cur ? idx_q : scan_idx;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_IDLE;
            resp_valid    <= 1'b0;
            resp_status_r <= STAT_OK;
            type_q        <= REQ_ADD;
            side_q        <= 1'b0;
            id_q          <= '0;
            qty_q         <= '0;
            idx_q         <= '0;
            scan_found    <= 1'b0;
            scan_idx      <= '0;
            scan_price    <= '0;
            for (int s = 0; s < 2; s++) begin
                ent_valid[s]    <= '0;
                best_valid_r[s] <= 1'b0;
                best_idx_r[s]   <= '0;
                best_id_r[s]    <= '0;
                best_qty_r[s]   <= '0;
                best_price_r[s] <= '0;
            end
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        type_q <= req_type_e'(req_type);
                        side_q <= side;
                        id_q   <= order_id;
                        qty_q  <= quantity;
                        idx_q  <= '0;
                        case (req_type_e'(req_type))
                            REQ_ADD: begin
                                resp_valid <= 1'b1;
                                if (quantity == '0) begin
                                    resp_status_r <= STAT_BAD_REQ;
                                end else if (!any_free[side]) begin
                                    resp_status_r <= STAT_FULL;
                                end else begin
                                    resp_status_r <= STAT_OK;
                                    ent_valid[side][free_idx[side]] <= 1'b1;
                                    ent_id[side][free_idx[side]]    <= order_id;
                                    ent_qty[side][free_idx[side]]   <= quantity;
                                    ent_price[side][free_idx[side]] <= price;
                                    if (add_better) begin
                                        best_valid_r[side] <= 1'b1;
                                        best_idx_r[side]   <= free_idx[side];
                                        best_id_r[side]    <= order_id;
                                        best_qty_r[side]   <= quantity;
                                        best_price_r[side] <= price;
                                    end
                                end
                            end
                            REQ_CANCEL, REQ_REDUCE: begin
                                state <= ST_SEARCH;
                            end
                            default: begin
                                resp_valid    <= 1'b1;
                                resp_status_r <= STAT_BAD_REQ;
                            end
                        endcase
                    end
                end
                ST_SEARCH: begin
                    if (hit) begin
                        if (hit_remove) begin
                            ent_valid[side_q][idx_q] <= 1'b0;
                            if (hit_is_best) begin
                                // Best outputs stay untouched until the rescan lands.
                                state      <= ST_RESCAN;
                                idx_q      <= '0;
                                scan_found <= 1'b0;
                                scan_idx   <= '0;
                                scan_price <= '0;
                            end else begin
                                state         <= ST_IDLE;
                                resp_valid    <= 1'b1;
                                resp_status_r <= STAT_OK;
                            end
                        end else begin
                            ent_qty[side_q][idx_q] <= reduced_qty;
                            if (hit_is_best) begin
                                best_qty_r[side_q] <= reduced_qty;
                            end
                            state         <= ST_IDLE;
                            resp_valid    <= 1'b1;
                            resp_status_r <= STAT_OK;
                        end
                    end else if (idx_q == LAST_IDX) begin
                        state         <= ST_IDLE;
                        resp_valid    <= 1'b1;
                        resp_status_r <= STAT_NOT_FOUND;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                ST_RESCAN: begin
                    if (idx_q == LAST_IDX) begin
                        best_valid_r[side_q] <= final_found;
                        best_idx_r[side_q]   <= final_found ? final_idx : '0;
                        best_id_r[side_q]    <= final_found ? ent_id[side_q][final_idx] : '0;
                        best_qty_r[side_q]   <= final_found ? ent_qty[side_q][final_idx] : '0;
                        best_price_r[side_q] <= final_found ? ent_price[side_q][final_idx] : '0;
                        state         <= ST_IDLE;
                        resp_valid    <= 1'b1;
                        resp_status_r <= STAT_OK;
                    end else begin
                        if (take_cur) begin
                            scan_found <= 1'b1;
                            scan_idx   <= idx_q;
                            scan_price <= ent_price[side_q][idx_q];
                        end
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = (state == ST_IDLE);
    assign resp_status = resp_status_r;

    assign bid_valid = best_valid_r[SIDE_BID];
    assign bid_id    = best_id_r[SIDE_BID];
    assign bid_qty   = best_qty_r[SIDE_BID];
    assign bid_price = best_price_r[SIDE_BID];
    assign ask_valid = best_valid_r[SIDE_ASK];
    assign ask_id    = best_id_r[SIDE_ASK];
    assign ask_qty   = best_qty_r[SIDE_ASK];
    assign ask_price = best_price_r[SIDE_ASK];

endmodule

// File: tb/tb_param_order_book.sv
// tb_param_order_book
// Self-checking bench for param_order_book at DEPTH=4: directed scenarios
// plus a randomized run against a behavioural book model.
module tb_param_order_book;
    import order_book_pkg::*;

    localparam int DEPTH   = 4;
    localparam int ID_W    = 32;
    localparam int QTY_W   = 32;
    localparam int PRICE_W = 64;
    localparam int TUP_W   = 1 + ID_W + QTY_W + PRICE_W;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         req_type;
    logic               side;
    logic [ID_W-1:0]    order_id;
    logic [QTY_W-1:0]   quantity;
    logic [PRICE_W-1:0] price;
    logic               resp_valid;
    logic [1:0]         resp_status;
    logic               bid_valid;
    logic [ID_W-1:0]    bid_id;
    logic [QTY_W-1:0]   bid_qty;
    logic [PRICE_W-1:0] bid_price;
    logic               ask_valid;
    logic [ID_W-1:0]    ask_id;
    logic [QTY_W-1:0]   ask_qty;
    logic [PRICE_W-1:0] ask_price;

    int vectors     = 0;
    int miscompares = 0;

    param_order_book #(.DEPTH(DEPTH), .ID_W(ID_W), .QTY_W(QTY_W), .PRICE_W(PRICE_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .req_type    (req_type),
        .side        (side),
        .order_id    (order_id),
        .quantity    (quantity),
        .price       (price),
        .resp_valid  (resp_valid),
        .resp_status (resp_status),
        .bid_valid   (bid_valid),
        .bid_id      (bid_id),
        .bid_qty     (bid_qty),
        .bid_price   (bid_price),
        .ask_valid   (ask_valid),
        .ask_id      (ask_id),
        .ask_qty     (ask_qty),
        .ask_price   (ask_price)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural book: slot arrays per side and the best slot per side.
    bit                 mv     [2][DEPTH];
    logic [ID_W-1:0]    mid    [2][DEPTH];
    logic [QTY_W-1:0]   mqty   [2][DEPTH];
    logic [PRICE_W-1:0] mprice [2][DEPTH];
    bit                 mbv    [2];
    int                 mbi    [2];

    function automatic bit m_better(input bit s, input logic [PRICE_W-1:0] a,
                                    input logic [PRICE_W-1:0] b);
        return s ? (a < b) : (a > b);
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 2; s++) begin
            mbv[s] = 0;
            mbi[s] = 0;
            for (int i = 0; i < DEPTH; i++) mv[s][i] = 0;
        end
    endfunction

    function automatic void model_best(input bit s);
        mbv[s] = 0;
        mbi[s] = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mv[s][i] && (!mbv[s] || m_better(s, mprice[s][i], mprice[s][mbi[s]]))) begin
                mbv[s] = 1;
                mbi[s] = i;
            end
        end
    endfunction

    function automatic logic [TUP_W-1:0] model_tuple(input bit s);
        if (!mbv[s]) return '0;
        return {1'b1, mid[s][mbi[s]], mqty[s][mbi[s]], mprice[s][mbi[s]]};
    endfunction

    // Expected status and response latency (cycles after acceptance).
    function automatic void model_req(input logic [1:0] t, input bit s,
                                      input logic [ID_W-1:0] id, input logic [QTY_W-1:0] q,
                                      input logic [PRICE_W-1:0] p,
                                      output logic [1:0] st, output int lat);
        int slot;
        slot = -1;
        st   = 2'd0;
        lat  = 1;
        if (t == 2'b00) begin
            if (q == 0) begin
                st = 2'd3;
            end else begin
                for (int i = DEPTH - 1; i >= 0; i--) if (!mv[s][i]) slot = i;
                if (slot < 0) begin
                    st = 2'd1;
                end else begin
                    mv[s][slot] = 1; mid[s][slot] = id; mqty[s][slot] = q; mprice[s][slot] = p;
                    if (!mbv[s] || m_better(s, p, mprice[s][mbi[s]])) begin
                        mbv[s] = 1;
                        mbi[s] = slot;
                    end
                end
            end
        end else if (t == 2'b01 || t == 2'b10) begin
            for (int i = DEPTH - 1; i >= 0; i--) if (mv[s][i] && mid[s][i] == id) slot = i;
            if (slot < 0) begin
                st  = 2'd2;
                lat = DEPTH + 1;
            end else if (t == 2'b01 || q >= mqty[s][slot]) begin
                mv[s][slot] = 0;
                if (mbv[s] && mbi[s] == slot) begin
                    model_best(s);
                    lat = 2 + slot + DEPTH;
                end else begin
                    lat = 2 + slot;
                end
            end else begin
                mqty[s][slot] = mqty[s][slot] - q;
                lat = 2 + slot;
            end
        end else begin
            st = 2'd3;
        end
    endfunction

    // Called at a negedge; returns at the negedge where resp_valid is seen.
    task automatic issue(input logic [1:0] t, input bit s, input logic [ID_W-1:0] id,
                         input logic [QTY_W-1:0] q, input logic [PRICE_W-1:0] p,
                         output bit got, output int lat, output logic [1:0] st,
                         output int waited, output bit early);
        logic [2*ID_W+1:0] snap;
        in_valid = 1'b1; req_type = t; side = s; order_id = id; quantity = q; price = p;
        waited = 0;
        while (!in_ready && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        snap = {bid_valid, bid_id, ask_valid, ask_id};
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        req_type = 2'($urandom);
        side     = 1'($urandom);
        order_id = $urandom;
        quantity = $urandom;
        price    = {$urandom, $urandom};
        got = 0; lat = 0; st = 2'd0; early = 0;
        for (int n = 1; n <= 3 * DEPTH + 8; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1;
                lat = n;
                st  = resp_status;
                break;
            end
            if ({bid_valid, bid_id, ask_valid, ask_id} !== snap) early = 1;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        bit got; int lat; int w; bit early; logic [1:0] st;
        apply_reset();
        issue(2'b00, 1'b0, 32'd7, 32'd3, 64'd55, got, lat, st, w, early);
        apply_reset();
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("[TB] FAIL reset_in_ready: got %0b, expected 1", in_ready);
        end
        vectors++;
        if (resp_valid !== 1'b0 || resp_status !== 2'd0) begin
            miscompares++; $display("[TB] FAIL reset_resp: got %0b/%0d, expected 0/0", resp_valid, resp_status);
        end
        vectors++;
        if ({bid_valid, bid_id, bid_qty, bid_price} !== '0) begin
            miscompares++; $display("[TB] FAIL reset_bid: got valid %0b id %0d, expected all zero", bid_valid, bid_id);
        end
        vectors++;
        if ({ask_valid, ask_id, ask_qty, ask_price} !== '0) begin
            miscompares++; $display("[TB] FAIL reset_ask: got valid %0b id %0d, expected all zero", ask_valid, ask_id);
        end
    endtask

    task automatic test_add_tie();
        bit got; int lat; int w; bit early; logic [1:0] st;
        apply_reset();
        issue(2'b00, 1'b0, 32'd1, 32'd10, 64'd100, got, lat, st, w, early);
        vectors++;
        if (!got || lat != 1 || st !== 2'd0) begin
            miscompares++; $display("[TB] FAIL add_first: got resp %0b lat %0d st %0d, expected 1/1/0", got, lat, st);
        end
        issue(2'b00, 1'b0, 32'd2, 32'd5, 64'd100, got, lat, st, w, early);
        vectors++;
        if (!got || lat != 1 || st !== 2'd0 || w != 0) begin
            miscompares++; $display("[TB] FAIL add_back_to_back: got resp %0b lat %0d st %0d wait %0d, expected 1/1/0/0", got, lat, st, w);
        end
        vectors++;
        if ({bid_valid, bid_id, bid_qty, bid_price} !== {1'b1, 32'd1, 32'd10, 64'd100}) begin
            miscompares++; $display("[TB] FAIL add_tie_best: got id %0d qty %0d price %0d, expected 1/10/100", bid_id, bid_qty, bid_price);
        end
    endtask

    task automatic test_full();
        bit got; int lat; int w; bit early; logic [1:0] st;
        logic [PRICE_W-1:0] prices [4] = '{64'd50, 64'd40, 64'd60, 64'd45};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            issue(2'b00, 1'b1, ID_W'(11 + i), 32'd7, prices[i], got, lat, st, w, early);
            vectors++;
            if (!got || st !== 2'd0) begin
                miscompares++; $display("[TB] FAIL fill_ask%0d: got resp %0b st %0d, expected 1/0", i, got, st);
            end
        end
        issue(2'b00, 1'b1, 32'd15, 32'd9, 64'd30, got, lat, st, w, early);
        vectors++;
        if (!got || lat != 1 || st !== 2'd1) begin
            miscompares++; $display("[TB] FAIL full_status: got resp %0b lat %0d st %0d, expected 1/1/1", got, lat, st);
        end
        vectors++;
        if ({ask_valid, ask_id, ask_qty, ask_price} !== {1'b1, 32'd12, 32'd7, 64'd40}) begin
            miscompares++; $display("[TB] FAIL full_best: got id %0d qty %0d price %0d, expected 12/7/40", ask_id, ask_qty, ask_price);
        end
    endtask

    task automatic test_cancel_best();
        bit got; int lat; int w; bit early; logic [1:0] st;
        apply_reset();
        issue(2'b00, 1'b0, 32'd21, 32'd1, 64'd100, got, lat, st, w, early);
        issue(2'b00, 1'b0, 32'd22, 32'd2, 64'd120, got, lat, st, w, early);
        issue(2'b00, 1'b0, 32'd23, 32'd3, 64'd90, got, lat, st, w, early);
        vectors++;
        if (bid_id !== 32'd22) begin
            miscompares++; $display("[TB] FAIL best_before_cancel: got %0d, expected 22", bid_id);
        end
        issue(2'b01, 1'b0, 32'd22, 32'd0, 64'd0, got, lat, st, w, early);
        vectors++;
        if (!got || lat != 3 + DEPTH || st !== 2'd0) begin
            miscompares++; $display("[TB] FAIL cancel_best_latency: got resp %0b lat %0d st %0d, expected 1/%0d/0", got, lat, st, 3 + DEPTH);
        end
        vectors++;
        if (early) begin
            miscompares++; $display("[TB] FAIL cancel_best_hold: got best change before response, expected hold");
        end
        vectors++;
        if ({bid_valid, bid_id, bid_qty, bid_price} !== {1'b1, 32'd21, 32'd1, 64'd100}) begin
            miscompares++; $display("[TB] FAIL cancel_best_new: got id %0d price %0d, expected 21/100", bid_id, bid_price);
        end
    endtask

    task automatic test_reduce();
        bit got; int lat; int w; bit early; logic [1:0] st;
        apply_reset();
        issue(2'b00, 1'b1, 32'd31, 32'd10, 64'd200, got, lat, st, w, early);
        issue(2'b00, 1'b1, 32'd32, 32'd4, 64'd250, got, lat, st, w, early);
        issue(2'b10, 1'b1, 32'd31, 32'd3, 64'd0, got, lat, st, w, early);
        vectors++;
        if (!got || lat != 2 || st !== 2'd0 || ask_qty !== 32'd7 || ask_id !== 32'd31) begin
            miscompares++; $display("[TB] FAIL reduce_partial: got lat %0d st %0d qty %0d id %0d, expected 2/0/7/31", lat, st, ask_qty, ask_id);
        end
        issue(2'b10, 1'b1, 32'd31, 32'd7, 64'd0, got, lat, st, w, early);
        vectors++;
        if (!got || lat != 2 + DEPTH || st !== 2'd0 || ask_id !== 32'd32 || ask_price !== 64'd250) begin
            miscompares++; $display("[TB] FAIL reduce_remove: got lat %0d st %0d id %0d price %0d, expected %0d/0/32/250", lat, st, ask_id, ask_price, 2 + DEPTH);
        end
        issue(2'b10, 1'b1, 32'd32, 32'd100, 64'd0, got, lat, st, w, early);
        vectors++;
        if (!got || lat != 3 + DEPTH || {ask_valid, ask_id, ask_qty, ask_price} !== '0) begin
            miscompares++; $display("[TB] FAIL reduce_empty: got lat %0d valid %0b id %0d, expected %0d/0/0", lat, ask_valid, ask_id, 3 + DEPTH);
        end
    endtask

    task automatic test_not_found_bad();
        bit got; int lat; int w; bit early; logic [1:0] st;
        apply_reset();
        issue(2'b00, 1'b0, 32'd41, 32'd5, 64'd10, got, lat, st, w, early);
        issue(2'b01, 1'b0, 32'd99, 32'd0, 64'd0, got, lat, st, w, early);
        vectors++;
        if (!got || lat != DEPTH + 1 || st !== 2'd2) begin
            miscompares++; $display("[TB] FAIL not_found: got resp %0b lat %0d st %0d, expected 1/%0d/2", got, lat, st, DEPTH + 1);
        end
        issue(2'b01, 1'b1, 32'd41, 32'd0, 64'd0, got, lat, st, w, early);
        vectors++;
        if (!got || lat != DEPTH + 1 || st !== 2'd2) begin
            miscompares++; $display("[TB] FAIL wrong_side: got resp %0b lat %0d st %0d, expected 1/%0d/2", got, lat, st, DEPTH + 1);
        end
        issue(2'b11, 1'b0, 32'd41, 32'd5, 64'd10, got, lat, st, w, early);
        vectors++;
        if (!got || lat != 1 || st !== 2'd3) begin
            miscompares++; $display("[TB] FAIL reserved_type: got resp %0b lat %0d st %0d, expected 1/1/3", got, lat, st);
        end
        issue(2'b00, 1'b1, 32'd42, 32'd0, 64'd10, got, lat, st, w, early);
        vectors++;
        if (!got || lat != 1 || st !== 2'd3 || ask_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL zero_qty_add: got lat %0d st %0d ask_valid %0b, expected 1/3/0", lat, st, ask_valid);
        end
    endtask

    task automatic test_reset_rescan();
        bit got; int lat; int w; bit early; logic [1:0] st;
        bit saw_resp;
        apply_reset();
        issue(2'b00, 1'b0, 32'd51, 32'd4, 64'd10, got, lat, st, w, early);
        in_valid = 1'b1; req_type = 2'b01; side = 1'b0; order_id = 32'd51;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        saw_resp = 0;
        repeat (2) begin
            @(negedge clk);
            if (resp_valid) saw_resp = 1;
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || bid_valid !== 1'b0 || ask_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL rescan_reset_state: got ready %0b bid %0b ask %0b, expected 1/0/0", in_ready, bid_valid, ask_valid);
        end
        reset = 1'b1;
        model_reset();
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) saw_resp = 1;
        end
        vectors++;
        if (saw_resp) begin
            miscompares++; $display("[TB] FAIL rescan_reset_no_resp: got resp_valid 1, expected 0");
        end
        issue(2'b00, 1'b0, 32'd52, 32'd5, 64'd77, got, lat, st, w, early);
        vectors++;
        if (!got || lat != 1 || st !== 2'd0 ||
            {bid_valid, bid_id, bid_qty, bid_price} !== {1'b1, 32'd52, 32'd5, 64'd77}) begin
            miscompares++; $display("[TB] FAIL add_after_reset: got lat %0d st %0d id %0d, expected 1/0/52", lat, st, bid_id);
        end
    endtask

    task automatic test_random();
        bit got; int lat; int w; bit early; logic [1:0] st;
        logic [1:0] t; bit s; logic [ID_W-1:0] id; logic [QTY_W-1:0] q; logic [PRICE_W-1:0] p;
        logic [1:0] exp_st; int exp_lat; int r;
        apply_reset();
        for (int n = 0; n < 250; n++) begin
            r  = $urandom_range(0, 9);
            t  = (r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            s  = 1'($urandom_range(0, 1));
            id = ID_W'($urandom_range(1, 6));
            q  = QTY_W'($urandom_range(0, 12));
            p  = PRICE_W'($urandom_range(1, 6) * 10);
            model_req(t, s, id, q, p, exp_st, exp_lat);
            issue(t, s, id, q, p, got, lat, st, w, early);
            vectors++;
            if (!got || lat != exp_lat || st !== exp_st || w != 0 || early) begin
                miscompares++;
                $display("[TB] FAIL rand_resp op %0d type %0d: got resp %0b lat %0d st %0d wait %0d early %0b, expected 1/%0d/%0d/0/0",
                         n, t, got, lat, st, w, early, exp_lat, exp_st);
            end
            vectors++;
            if ({bid_valid, bid_id, bid_qty, bid_price} !== model_tuple(1'b0)) begin
                miscompares++;
                $display("[TB] FAIL rand_bid op %0d: got %0b/%0d/%0d/%0d, expected %0h",
                         n, bid_valid, bid_id, bid_qty, bid_price, model_tuple(1'b0));
            end
            vectors++;
            if ({ask_valid, ask_id, ask_qty, ask_price} !== model_tuple(1'b1)) begin
                miscompares++;
                $display("[TB] FAIL rand_ask op %0d: got %0b/%0d/%0d/%0d, expected %0h",
                         n, ask_valid, ask_id, ask_qty, ask_price, model_tuple(1'b1));
            end
        end
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        req_type = 2'b00;
        side     = 1'b0;
        order_id = '0;
        quantity = '0;
        price    = '0;
        model_reset();
        test_reset();
        test_add_tie();
        test_full();
        test_cancel_best();
        test_reduce();
        test_not_found_bad();
        test_reset_rescan();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
